// File: rtl/fetch_decode_stage.sv
// fetch_decode_stage: IF/ID register with early branch redirect and wrong-path squash.
// Optional BRANCH_STATS_EN adds saturating taken/squash counters.
module fetch_decode_stage #(
  parameter int          FLUSH_CYCLES = 1,
  parameter int          PC_W         = 7,
  parameter logic [3:0]  OP_B         = 4'b1000,
  parameter logic [3:0]  OP_BEQ       = 4'b1001
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     Instruccion,
  input  logic            zero_flag_i,
  output logic [PC_W-1:0] branchResultOut,
`ifdef BRANCH_STATS_EN
  output logic [15:0]     taken_cnt_o,
  output logic [15:0]     squash_cnt_o,
`endif
  output logic [31:0]     instr_id_o,
  output logic [PC_W-1:0] pc_id_o,
  output logic            valid_id_o,
  output logic            bad_target_o
);
  typedef enum logic [1:0] {WARM, RUN, SQUASH} state_t;
  state_t          state_q;
  logic [1:0]      cnt_q;
  logic [PC_W-1:0] pc_q, bro_q, pc_id_q;
  logic [31:0]     instr_q;
  logic            valid_q, bad_q;
  logic [3:0]      opcode;
  logic [PC_W-1:0] target;
  logic            is_br, taken;
  assign opcode = Instruccion[31:28];
  assign target = Instruccion[PC_W-1:0];
  assign is_br  = (opcode == OP_B) || ((opcode == OP_BEQ) && zero_flag_i);
  // a zero target would look like "no redirect" on the bus, so it never counts as taken
  assign taken  = is_br && (target != '0);
  // pc_q is the address of the word currently on Instruccion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WARM;
      cnt_q   <= '0;
      pc_q    <= '0;
      bro_q   <= '0;
      pc_id_q <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      bro_q <= '0;
      case (state_q)
        WARM: state_q <= RUN;
        RUN: begin
          instr_q <= Instruccion;
          valid_q <= 1'b1;
          pc_id_q <= pc_q;
          pc_q    <= taken ? target : pc_q + PC_W'(1);
          if (taken) begin
            bro_q   <= target;
            state_q <= SQUASH;
            cnt_q   <= 2'(FLUSH_CYCLES);
          end
          if (is_br && target == '0) bad_q <= 1'b1;
        end
        default: begin
          // wrong-path words do not consume the redirected PC
          instr_q <= Instruccion;
          valid_q <= 1'b0;
          pc_id_q <= pc_q;
          cnt_q   <= cnt_q - 2'd1;
          state_q <= (cnt_q == 2'd1) ? RUN : SQUASH;
        end
      endcase
    end
  end
`ifdef BRANCH_STATS_EN
  logic [15:0] taken_cnt_q, squash_cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_cnt_q  <= '0;
      squash_cnt_q <= '0;
    end else begin
      if (state_q == RUN && taken && taken_cnt_q != 16'hFFFF) taken_cnt_q <= taken_cnt_q + 16'd1;
      if (state_q == SQUASH && squash_cnt_q != 16'hFFFF) squash_cnt_q <= squash_cnt_q + 16'd1;
    end
  end
  assign taken_cnt_o  = taken_cnt_q;
  assign squash_cnt_o = squash_cnt_q;
`endif
  assign branchResultOut = bro_q;
  assign instr_id_o      = instr_q;
  assign pc_id_o         = pc_id_q;
  assign valid_id_o      = valid_q;
  assign bad_target_o    = bad_q;
endmodule

// File: tb/tb_fetch_decode_stage.sv
// tb_fetch_decode_stage: directed self-checking bench for fetch_decode_stage (FLUSH_CYCLES=1).
module tb_fetch_decode_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] Instruccion = '0;
  logic        zero_flag_i = 1'b0;
  logic [6:0]  branchResultOut, pc_id_o;
  logic [31:0] instr_id_o;
  logic        valid_id_o, bad_target_o;
`ifdef BRANCH_STATS_EN
  logic [15:0] taken_cnt_o, squash_cnt_o;
`endif
  int checks = 0;
  int failures = 0;
  fetch_decode_stage dut (
    .clk(clk), .rst_n(rst_n), .Instruccion(Instruccion), .zero_flag_i(zero_flag_i),
    .branchResultOut(branchResultOut),
`ifdef BRANCH_STATS_EN
    .taken_cnt_o(taken_cnt_o), .squash_cnt_o(squash_cnt_o),
`endif
    .instr_id_o(instr_id_o), .pc_id_o(pc_id_o), .valid_id_o(valid_id_o), .bad_target_o(bad_target_o)
  );
  always #5 clk = ~clk;
  task automatic step(input logic [31:0] w, input logic z);
    Instruccion = w;
    zero_flag_i = z;
    @(posedge clk);
    #1;
  endtask
  // each row: word, zero flag, expected {valid, pc, redirect, bad}, expected instr
  typedef struct {
    string       name;
    logic [31:0] w;
    logic        z;
    logic        v;
    logic [6:0]  pc;
    logic [6:0]  bro;
    logic        bad;
  } vec_t;
  task automatic run_vec(input vec_t t);
    step(t.w, t.z);
    checks++;
    if ({valid_id_o, pc_id_o, branchResultOut, bad_target_o} !== {t.v, t.pc, t.bro, t.bad}) begin
      failures++;
      $display("FAIL %s got v=%b pc=%h bro=%h bad=%b exp v=%b pc=%h bro=%h bad=%b", t.name,
               valid_id_o, pc_id_o, branchResultOut, bad_target_o, t.v, t.pc, t.bro, t.bad);
    end
    checks++;
    if (instr_id_o !== t.w) begin
      failures++;
      $display("FAIL %s_instr got %h exp %h", t.name, instr_id_o, t.w);
    end
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++;
    if ({valid_id_o, pc_id_o, branchResultOut, bad_target_o, instr_id_o} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b pc=%h bro=%h bad=%b ins=%h exp all 0",
               valid_id_o, pc_id_o, branchResultOut, bad_target_o, instr_id_o);
    end
`ifdef BRANCH_STATS_EN
    checks++;
    if ({taken_cnt_o, squash_cnt_o} !== 32'h0) begin
      failures++;
      $display("FAIL reset_stats got %h/%h exp 0/0", taken_cnt_o, squash_cnt_o);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step(32'hA0000001, 1'b0);
    checks++;
    if ({valid_id_o, instr_id_o, pc_id_o} !== '0) begin
      failures++;
      $display("FAIL warm_cycle got v=%b ins=%h pc=%h exp 0 0 0", valid_id_o, instr_id_o, pc_id_o);
    end
  endtask
  task automatic test_straight_line;
    run_vec('{"seq0", 32'hA0000001, 1'b0, 1'b1, 7'h00, 7'h00, 1'b0});
    run_vec('{"seq1", 32'hA0000002, 1'b0, 1'b1, 7'h01, 7'h00, 1'b0});
    run_vec('{"seq2", 32'hA0000003, 1'b0, 1'b1, 7'h02, 7'h00, 1'b0});
    run_vec('{"seq3", 32'hA0000004, 1'b0, 1'b1, 7'h03, 7'h00, 1'b0});
    run_vec('{"seq4", 32'hA0000005, 1'b1, 1'b1, 7'h04, 7'h00, 1'b0});
  endtask
  task automatic test_branch;
    run_vec('{"b_issue", 32'h80000015, 1'b0, 1'b1, 7'h05, 7'h15, 1'b0});
    run_vec('{"b_squash", 32'hA0000006, 1'b0, 1'b0, 7'h15, 7'h00, 1'b0});
    run_vec('{"b_target", 32'hA0000015, 1'b0, 1'b1, 7'h15, 7'h00, 1'b0});
    run_vec('{"b_after", 32'hA0000016, 1'b0, 1'b1, 7'h16, 7'h00, 1'b0});
  endtask
  task automatic test_beq;
    run_vec('{"beq_nt", 32'h90000030, 1'b0, 1'b1, 7'h17, 7'h00, 1'b0});
    run_vec('{"beq_t", 32'h90000030, 1'b1, 1'b1, 7'h18, 7'h30, 1'b0});
    run_vec('{"beq_squash", 32'hA0000019, 1'b0, 1'b0, 7'h30, 7'h00, 1'b0});
    run_vec('{"beq_target", 32'hA0000030, 1'b0, 1'b1, 7'h30, 7'h00, 1'b0});
  endtask
  task automatic test_bad_target;
    run_vec('{"bad_issue", 32'h80000000, 1'b0, 1'b1, 7'h31, 7'h00, 1'b1});
    run_vec('{"bad_sticky", 32'hA0000032, 1'b0, 1'b1, 7'h32, 7'h00, 1'b1});
  endtask
  task automatic test_back_to_back;
    run_vec('{"bb_first", 32'h80000010, 1'b0, 1'b1, 7'h33, 7'h10, 1'b1});
    run_vec('{"bb_second", 32'h80000040, 1'b0, 1'b0, 7'h10, 7'h00, 1'b1});
    run_vec('{"bb_target", 32'hA0000010, 1'b0, 1'b1, 7'h10, 7'h00, 1'b1});
  endtask
  task automatic test_wrap;
    run_vec('{"wr_issue", 32'h9000007F, 1'b1, 1'b1, 7'h11, 7'h7F, 1'b1});
    run_vec('{"wr_squash", 32'hA0000012, 1'b0, 1'b0, 7'h7F, 7'h00, 1'b1});
    run_vec('{"wr_7f", 32'hA000007F, 1'b0, 1'b1, 7'h7F, 7'h00, 1'b1});
    run_vec('{"wr_zero", 32'hA0000080, 1'b0, 1'b1, 7'h00, 7'h00, 1'b1});
  endtask
  task automatic test_reset_mid_squash;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step(32'hA0000000, 1'b0);
    run_vec('{"rs_pre", 32'hA0000001, 1'b0, 1'b1, 7'h00, 7'h00, 1'b0});
    run_vec('{"rs_br", 32'h80000020, 1'b0, 1'b1, 7'h01, 7'h20, 1'b0});
`ifdef BRANCH_STATS_EN
    step(32'hA0000002, 1'b0);
    checks++;
    if ({taken_cnt_o, squash_cnt_o} !== {16'd1, 16'd1}) begin
      failures++;
      $display("FAIL stats_one got %h/%h exp 1/1", taken_cnt_o, squash_cnt_o);
    end
    run_vec('{"rs_br2", 32'h80000020, 1'b0, 1'b1, 7'h20, 7'h20, 1'b0});
`endif
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({valid_id_o, pc_id_o, branchResultOut, bad_target_o, instr_id_o} !== '0) begin
      failures++;
      $display("FAIL rs_async got v=%b pc=%h bro=%h bad=%b ins=%h exp all 0",
               valid_id_o, pc_id_o, branchResultOut, bad_target_o, instr_id_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(32'hA0000003, 1'b0);
    checks++;
    if ({valid_id_o, branchResultOut} !== '0) begin
      failures++;
      $display("FAIL rs_warm got v=%b bro=%h exp 0 0", valid_id_o, branchResultOut);
    end
    run_vec('{"rs_first", 32'hA0000004, 1'b0, 1'b1, 7'h00, 7'h00, 1'b0});
    run_vec('{"rs_second", 32'hA0000005, 1'b0, 1'b1, 7'h01, 7'h00, 1'b0});
  endtask
  initial begin
    test_reset;
    test_straight_line;
    test_branch;
    test_beq;
    test_bad_target;
    test_back_to_back;
    test_wrap;
    test_reset_mid_squash;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
